// File: rtl/multi_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// multi_rate_tick_gen
//
// Purpose:
//   Generates NUM_CH independent single-cycle enable strobes ("ticks"), each
//   with its own runtime-programmable period, pause control and one-shot
//   mode. All channels share one clock domain. Game logic uses tick[i] as a
//   clock enable instead of raw divided-clock bits. A legacy free-running
//   counter is also provided for blocks that still expect divided-clock bits.
//
// Parameters:
//   NUM_CH         number of tick channels (1..16)
//   CNT_W          width of period registers, channel counters, free_count
//   DEFAULT_PERIOD period loaded into every channel at reset
//
// Ports:
//   clk          in   system clock (CLOCK_50 at top level)
//   reset        in   asynchronous active-low reset, clears all state
//   cfg_we       in   configuration write strobe
//   cfg_ch       in   channel index for the write (>= NUM_CH is ignored)
//   cfg_period   in   new period in clk cycles (0 disables the channel)
//   cfg_oneshot  in   new one-shot mode bit
//   ch_en        in   per-channel run enable, low pauses the channel
//   sync_clr     in   synchronous clear of all counters and done flags
//   tick         out  one-cycle strobe per channel
//   done         out  one-shot channel has fired and stopped
//   free_count   out  free-running cycle counter
//   sq_out       out  square wave toggled on every tick (optional)
//
// Optional feature:
//   Define TICK_SQUARE_OUT_EN to add the sq_out port, a registered square
//   wave of period 2*P[i] per channel, matching old divided_clocks usage.
// ---------------------------------------------------------------------------
module multi_rate_tick_gen #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done,
`ifdef TICK_SQUARE_OUT_EN
    output logic [NUM_CH-1:0] sq_out,
`endif
    output logic [CNT_W-1:0]  free_count
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [NUM_CH-1:0] oneshot_q;
    logic [NUM_CH-1:0] en_q;
    logic              started_q;

    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] at_wrap;
    logic [NUM_CH-1:0] en_fall;

    // Per-channel decode of the current cycle.
    // started_q holds every channel idle on the first edge after reset is
    // released, so no tick can appear in the cycle right after release even
    // for a period of 1. A write whose index is out of range matches no
    // channel and therefore changes nothing.
    always_comb begin
        cfg_hit = '0;
        running = '0;
        at_wrap = '0;
        en_fall = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == 4'(i));
            running[i] = started_q && ch_en[i] && (period_q[i] != '0) && !done[i];
            at_wrap[i] = (count_q[i] == period_q[i] - ONE);
            en_fall[i] = en_q[i] && !ch_en[i];
        end
    end

    // Free-running legacy counter; nothing but reset affects it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_count <= '0;
        end else begin
            free_count <= free_count + ONE;
        end
    end

    // Channel state update.
    // Priority per channel: sync_clr, then a configuration write, then
    // normal counting. A write landing on the wrap cycle therefore swallows
    // that tick and restarts the count. A paused channel keeps its count so
    // re-enabling resumes where it left off. Dropping ch_en re-arms a
    // channel that has completed its one-shot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= DEF_P;
                count_q[i]  <= '0;
            end
            oneshot_q <= '0;
            en_q      <= '0;
            started_q <= 1'b0;
            tick      <= '0;
            done      <= '0;
`ifdef TICK_SQUARE_OUT_EN
            sq_out    <= '0;
`endif
        end else begin
            started_q <= 1'b1;
            en_q      <= ch_en;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_clr) begin
                    count_q[i] <= '0;
                    done[i]    <= 1'b0;
                    tick[i]    <= 1'b0;
`ifdef TICK_SQUARE_OUT_EN
                    sq_out[i]  <= 1'b0;
`endif
                end else if (cfg_hit[i]) begin
                    period_q[i]  <= cfg_period;
                    oneshot_q[i] <= cfg_oneshot;
                    count_q[i]   <= '0;
                    done[i]      <= 1'b0;
                    tick[i]      <= 1'b0;
`ifdef TICK_SQUARE_OUT_EN
                    sq_out[i]    <= 1'b0;
`endif
                end else begin
                    tick[i] <= 1'b0;
                    if (running[i]) begin
                        if (at_wrap[i]) begin
                            count_q[i] <= '0;
                            tick[i]    <= 1'b1;
                            if (oneshot_q[i]) begin
                                done[i] <= 1'b1;
                            end
`ifdef TICK_SQUARE_OUT_EN
                            sq_out[i]  <= !sq_out[i];
`endif
                        end else begin
                            count_q[i] <= count_q[i] + ONE;
                        end
                    end
                    if (en_fall[i]) begin
                        done[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
